// File: rtl/dbus_pkg.sv
// Shared types and constants for the CPU data-bus bridge.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          NSLOT            = 4;
    localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hdeadbeef;

endpackage

// File: rtl/mod_dbus_bridge_if.sv
// CPU data port plus peripheral slot bus. The master side is the CPU and the
// slot devices together; the slave side is the bridge.
interface mod_dbus_bridge_if;
    import dbus_pkg::*;

    logic                   cpu_de;
    logic [31:0]            cpu_daddr;
    logic                   cpu_drw;
    logic [31:0]            cpu_din;
    logic [31:0]            cpu_dout;
    logic                   cpu_stall;
    logic [NSLOT-1:0]       slot_de;
    logic [31:0]            slot_daddr;
    logic                   slot_drw;
    logic [31:0]            slot_din;
    logic [NSLOT*32-1:0]    slot_dout;
    logic [NSLOT-1:0]       slot_ack;
    logic                   err_clr;
    logic                   bus_err;
    logic [31:0]            err_addr;

    modport master (
        output cpu_de, cpu_daddr, cpu_drw, cpu_din, slot_dout, slot_ack, err_clr,
        input  cpu_dout, cpu_stall, slot_de, slot_daddr, slot_drw, slot_din,
               bus_err, err_addr
    );

    modport slave (
        input  cpu_de, cpu_daddr, cpu_drw, cpu_din, slot_dout, slot_ack, err_clr,
        output cpu_dout, cpu_stall, slot_de, slot_daddr, slot_drw, slot_din,
               bus_err, err_addr
    );

endinterface

// File: rtl/mod_dbus_decode.sv
// Address-to-slot decoder: matches the top address byte against the slot
// bases; when bases overlap the lowest slot index wins.
module mod_dbus_decode
    import dbus_pkg::*;
#(
    parameter logic [7:0] SLOT0_BASE = 8'hf0,
    parameter logic [7:0] SLOT1_BASE = 8'hf1,
    parameter logic [7:0] SLOT2_BASE = 8'hf2,
    parameter logic [7:0] SLOT3_BASE = 8'hf3
) (
    input  logic [7:0] addr_hi_i,
    output logic [1:0] idx_o,
    output logic       hit_o
);

    localparam logic [7:0] BASES [NSLOT] = '{SLOT0_BASE, SLOT1_BASE, SLOT2_BASE, SLOT3_BASE};

    // Scan from the top down so a lower matching index overrides a higher one.
    always_comb begin
        idx_o = 2'd0;
        hit_o = 1'b0;
        for (int n = NSLOT - 1; n >= 0; n--) begin
            if (addr_hi_i == BASES[n]) begin
                idx_o = 2'(n);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_dbus_bridge.sv
// Registered CPU-to-peripheral bridge: one outstanding access, CPU stalled
// until the selected slot acks, times out, or the address is unmapped.
module mod_dbus_bridge
    import dbus_pkg::*;
#(
    parameter logic [7:0]  SLOT0_BASE   = 8'hf0,
    parameter logic [7:0]  SLOT1_BASE   = 8'hf1,
    parameter logic [7:0]  SLOT2_BASE   = 8'hf2,
    parameter logic [7:0]  SLOT3_BASE   = 8'hf3,
    parameter int          TIMEOUT      = 16,
    parameter logic [31:0] TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
    input  logic              clk,
    input  logic              rst,
    mod_dbus_bridge_if.slave  bus
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic        drw_q,      drw_d;
    logic [31:0] din_q,      din_d;
    logic [1:0]  sel_q,      sel_d;
    logic [15:0] cnt_q,      cnt_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        bus_err_q,  bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        err_set;
    logic [31:0] err_set_addr;
    logic [1:0]  dec_idx;
    logic        dec_hit;

    mod_dbus_decode #(
        .SLOT0_BASE (SLOT0_BASE),
        .SLOT1_BASE (SLOT1_BASE),
        .SLOT2_BASE (SLOT2_BASE),
        .SLOT3_BASE (SLOT3_BASE)
    ) u_decode (
        .addr_hi_i (bus.cpu_daddr[31:24]),
        .idx_o     (dec_idx),
        .hit_o     (dec_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            drw_q      <= 1'b0;
            din_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            drw_q      <= drw_d;
            din_q      <= din_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        drw_d        = drw_q;
        din_d        = din_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        bus_err_d    = bus_err_q;
        err_addr_d   = err_addr_q;
        err_set      = 1'b0;
        err_set_addr = addr_q;

        case (state_q)
            IDLE: begin
                if (bus.cpu_de) begin
                    addr_d = bus.cpu_daddr;
                    drw_d  = bus.cpu_drw;
                    din_d  = bus.cpu_din;
                    if (dec_hit) begin
                        sel_d   = dec_idx;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        rdata_d      = '0;
                        err_set      = 1'b1;
                        err_set_addr = bus.cpu_daddr;
                        state_d      = DONE;
                    end
                end
            end
            BUSY: begin
                // Ack is checked before the count so a last-cycle ack still completes cleanly.
                if (bus.slot_ack[sel_q]) begin
                    rdata_d = drw_q ? 32'd0 : bus.slot_dout[{sel_q, 5'd0} +: 32];
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = drw_q ? 32'd0 : TIMEOUT_DATA;
                    err_set = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Only the first failure since the last clear is recorded.
        if (err_set) begin
            if (!bus_err_q) err_addr_d = err_set_addr;
            bus_err_d = 1'b1;
        end else if (bus.err_clr) begin
            bus_err_d = 1'b0;
        end
    end

    assign bus.cpu_stall  = (state_q == IDLE) ? bus.cpu_de : (state_q == BUSY);
    assign bus.cpu_dout   = rdata_q;
    assign bus.slot_de    = (state_q == BUSY) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.slot_daddr = {8'h00, addr_q[23:0]};
    assign bus.slot_drw   = drw_q;
    assign bus.slot_din   = din_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.err_addr   = err_addr_q;

endmodule

// File: tb/tb_mod_dbus_bridge.sv
// Directed bench for mod_dbus_bridge with a per-slot programmable ack delay.
module tb_mod_dbus_bridge;
    import dbus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_dbus_bridge_if bus ();

    mod_dbus_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // ack_dly: 0 = tied high, N>0 = ack in BUSY cycle N+1, <0 = never
    int ack_dly [4];
    int busy_cnt = 0;

    always @(posedge clk) busy_cnt <= (bus.slot_de != 4'b0) ? busy_cnt + 1 : 0;

    always_comb begin
        bus.slot_ack = 4'b0000;
        for (int n = 0; n < 4; n++)
            bus.slot_ack[n] = (ack_dly[n] == 0) || (ack_dly[n] > 0 && busy_cnt >= ack_dly[n]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Starts at posedge+1 in IDLE, ends at posedge+1 of the IDLE cycle after DONE with cpu_de low.
    task automatic access(input logic [31:0] a, input logic rw, input logic [31:0] d,
                          output int nst, output int nde, output logic [3:0] de_or,
                          output logic [31:0] rd, output logic [31:0] sa,
                          output logic [31:0] sd, output logic sw);
        bus.cpu_de    = 1'b1;
        bus.cpu_daddr = a;
        bus.cpu_drw   = rw;
        bus.cpu_din   = d;
        nst = 0; nde = 0; de_or = 4'b0; rd = '0; sa = '0; sd = '0; sw = 1'b0;
        #1;
        while (bus.cpu_stall && nst < 200) begin
            nst++;
            if (bus.slot_de != 4'b0) begin
                nde++;
                de_or = de_or | bus.slot_de;
                sa = bus.slot_daddr;
                sd = bus.slot_din;
                sw = bus.slot_drw;
            end
            @(posedge clk);
            #2;
        end
        if (nst >= 200) chk("stall_bound", 32'(nst), 32'd0);
        rd = bus.cpu_dout;
        @(posedge clk);
        #1;
        bus.cpu_de = 1'b0;
    endtask

    int          nst, nde;
    logic [3:0]  de_or;
    logic [31:0] rd, sa, sd;
    logic        sw;

    initial begin
        rst = 1'b0;
        bus.cpu_de = 1'b0; bus.cpu_daddr = '0; bus.cpu_drw = 1'b0; bus.cpu_din = '0;
        bus.err_clr = 1'b0;
        bus.slot_dout = {32'h33333333, 32'h22222222, 32'h11111111, 32'h017d7840};
        for (int n = 0; n < 4; n++) ack_dly[n] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",   32'(dut.state_q), 32'(IDLE));
        chk("rst_slot_de", 32'(bus.slot_de), 32'd0);
        chk("rst_stall",   32'(bus.cpu_stall), 32'd0);
        chk("rst_dout",    bus.cpu_dout, 32'd0);
        chk("rst_err",     32'(bus.bus_err), 32'd0);
        chk("rst_eaddr",   bus.err_addr, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // read slot 0, single-cycle device
        access(32'hf0000004, 1'b0, 32'd0, nst, nde, de_or, rd, sa, sd, sw);
        chk("rd0_stall", 32'(nst), 32'd2);
        chk("rd0_de",    32'(de_or), 32'b0001);
        chk("rd0_dout",  rd, 32'h017d7840);
        chk("rd0_saddr", sa, 32'h00000004);
        chk("rd0_err",   32'(bus.bus_err), 32'd0);

        // write slot 2, ack delayed 5 cycles
        ack_dly[2] = 5;
        access(32'hf2000010, 1'b1, 32'h12345678, nst, nde, de_or, rd, sa, sd, sw);
        chk("wr2_de",     32'(de_or), 32'b0100);
        chk("wr2_decyc",  32'(nde), 32'd6);
        chk("wr2_stall",  32'(nst), 32'd7);
        chk("wr2_din",    sd, 32'h12345678);
        chk("wr2_drw",    32'(sw), 32'd1);
        chk("wr2_saddr",  sa, 32'h00000010);
        chk("wr2_dout",   rd, 32'd0);
        ack_dly[2] = 0;

        // unmapped read, then a second failure, then clear
        access(32'h10000000, 1'b0, 32'd0, nst, nde, de_or, rd, sa, sd, sw);
        chk("um_decyc",  32'(nde), 32'd0);
        chk("um_stall",  32'(nst), 32'd1);
        chk("um_dout",   rd, 32'd0);
        chk("um_err",    32'(bus.bus_err), 32'd1);
        chk("um_eaddr",  bus.err_addr, 32'h10000000);
        access(32'h20000000, 1'b1, 32'h0, nst, nde, de_or, rd, sa, sd, sw);
        chk("um2_eaddr", bus.err_addr, 32'h10000000);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        chk("clr_err",   32'(bus.bus_err), 32'd0);
        chk("clr_eaddr", bus.err_addr, 32'h10000000);

        // read slot 1 with no ack -> timeout
        ack_dly[1] = -1;
        access(32'hf1000000, 1'b0, 32'd0, nst, nde, de_or, rd, sa, sd, sw);
        chk("to_de",    32'(de_or), 32'b0010);
        chk("to_decyc", 32'(nde), 32'd16);
        chk("to_dout",  rd, 32'hdeadbeef);
        chk("to_err",   32'(bus.bus_err), 32'd1);
        chk("to_eaddr", bus.err_addr, 32'hf1000000);
        ack_dly[1] = 0;

        // reset in the middle of a slot 3 read
        ack_dly[3] = -1;
        bus.cpu_de = 1'b1; bus.cpu_daddr = 32'hf3000000; bus.cpu_drw = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_busy_de", 32'(bus.slot_de), 32'b1000);
        rst = 1'b0;
        bus.cpu_de = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_slot_de", 32'(bus.slot_de), 32'd0);
        chk("mr_stall",   32'(bus.cpu_stall), 32'd0);
        chk("mr_state",   32'(dut.state_q), 32'(IDLE));
        chk("mr_dout",    bus.cpu_dout, 32'd0);
        chk("mr_err",     32'(bus.bus_err), 32'd0);
        rst = 1'b1;
        ack_dly[3] = 0;
        @(posedge clk);
        #1;
        access(32'hf3000004, 1'b0, 32'd0, nst, nde, de_or, rd, sa, sd, sw);
        chk("mr_rd_de",   32'(de_or), 32'b1000);
        chk("mr_rd_dout", rd, 32'h33333333);
        chk("mr_rd_err",  32'(bus.bus_err), 32'd0);

        // back-to-back reads of slot 0 then slot 1
        access(32'hf0000000, 1'b0, 32'd0, nst, nde, de_or, rd, sa, sd, sw);
        chk("bb0_de",    32'(de_or), 32'b0001);
        chk("bb0_decyc", 32'(nde), 32'd1);
        chk("bb0_dout",  rd, 32'h017d7840);
        access(32'hf1000008, 1'b0, 32'd0, nst, nde, de_or, rd, sa, sd, sw);
        chk("bb1_de",    32'(de_or), 32'b0010);
        chk("bb1_decyc", 32'(nde), 32'd1);
        chk("bb1_saddr", sa, 32'h00000008);
        chk("bb1_dout",  rd, 32'h11111111);
        @(posedge clk);
        #1;
        chk("bb_idle_de", 32'(bus.slot_de), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_dbus_bridge.md
Name: mod_dbus_bridge

Overview:
Registered data-bus bridge between the CPU data port and the memory-mapped peripherals (plpid, timer, uart, gpio).
- Decodes daddr[31:24] into one of four device slots.
- Drives the selected slot with a latched request and holds the CPU in stall until the slot acks.
- Returns the read data to the CPU.
- Unmapped accesses and slot timeouts complete with fixed data and set a sticky error flag.

Parameters:
SLOT0_BASE, 8'hf0, daddr[31:24] match for slot 0
SLOT1_BASE, 8'hf1, daddr[31:24] match for slot 1
SLOT2_BASE, 8'hf2, daddr[31:24] match for slot 2
SLOT3_BASE, 8'hf3, daddr[31:24] match for slot 3
TIMEOUT, 16, BUSY cycles without ack before forced completion (2..65535)
TIMEOUT_DATA, 32'hdeadbeef, read data returned on timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
cpu_de  in  1  CPU data access request; held until cpu_stall low
cpu_daddr  in  32  CPU byte address
cpu_drw  in  1  1=write, 0=read
cpu_din  in  32  CPU write data
cpu_dout  out  32  read data, valid in the cycle cpu_stall drops
cpu_stall  out  1  CPU hold
slot_de  out  4  one-hot slot enable
slot_daddr  out  32  {8'h00, latched daddr[23:0]}
slot_drw  out  1  latched drw
slot_din  out  32  latched din
slot_dout  in  128  slot n read data on bits [32n+31:32n]
slot_ack  in  4  slot n done; tie high for single-cycle devices
err_clr  in  1  clears bus_err
bus_err  out  1  sticky error flag
err_addr  out  32  daddr of the first failing access since last clear

Behaviour:
Interface: one clock, clk. Reset rst is synchronous and active-low.

Reset (rst==0 at a clk edge):
- state=IDLE; slot_de=0; cpu_stall=0; cpu_dout=0; bus_err=0; err_addr=0.
- Any access in progress is abandoned and no slot is enabled afterwards.

Decode:
- hit[n] = (cpu_daddr[31:24]==SLOTn_BASE).
- Overlapping bases: the lowest n wins.
- No hit = unmapped.

States: IDLE, BUSY, DONE.

IDLE:
- cpu_stall = cpu_de (combinational).
- On cpu_de with a hit: latch addr/drw/din/slot index, clear the timeout counter, go to BUSY.
- On cpu_de unmapped: rdata_q<=0, set error, go to DONE.

BUSY:
- cpu_stall=1.
- slot_de[sel]=1; slot_daddr/drw/din driven from the latched values.
- On slot_ack[sel]: rdata_q <= drw ? 0 : slot_dout[sel], go to DONE.
- Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack: rdata_q<=TIMEOUT_DATA (0 on a write), set error, go to DONE.
- Ack on the final count cycle takes priority over the timeout.

DONE:
- cpu_stall=0; cpu_dout=rdata_q; slot_de=0.
- Unconditionally go to IDLE. cpu_de in this cycle is the completing request and is ignored.

Timing and outputs:
- Minimum latency with immediate ack: de at cycle t, stall high t and t+1, stall low with data at t+2.
- cpu_dout is registered and holds rdata_q outside DONE.
- slot_de is zero outside BUSY.

Error register:
- set error: if bus_err==0 then err_addr<=latched daddr; bus_err<=1.
- err_clr clears bus_err in the next cycle.
- A set and err_clr in the same cycle: set wins.
- err_addr is unchanged by err_clr.

Requests:
- Requests must be held by the CPU while stalled.
- A change of cpu_daddr during BUSY has no effect (the latched values are used).

Decomposition:
- Package dbus_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), slot count constant NSLOT=4, default TIMEOUT_DATA.
- One combinational sub-module, mod_dbus_decode: cpu_daddr[31:24] + bases -> 2-bit slot index + hit flag, lowest-index priority.

Test Plan:
- Read slot 0 (plpid at daddr 32'hf0000004), slot_ack tied 1, slot_dout[31:0]=32'h017d7840: stall high 2 cycles; cpu_dout=32'h017d7840 on the third cycle; slot_daddr=32'h00000004; bus_err=0.
- Write slot 2 at 32'hf2000010 with din=32'h12345678, ack delayed 5 cycles: slot_de=4'b0100 for 6 cycles; slot_din=32'h12345678, slot_drw=1; stall drops the cycle after ack; cpu_dout=0.
- Read unmapped 32'h10000000: slot_de never asserts; cpu_dout=0 at t+1; bus_err=1, err_addr=32'h10000000. A second failing access leaves err_addr unchanged. err_clr -> bus_err=0.
- Read slot 1 with ack held 0, TIMEOUT=16: slot_de[1] high exactly 16 cycles; cpu_dout=32'hdeadbeef; bus_err=1, err_addr=32'hf1000000.
- rst driven low during BUSY of a slot 3 read: next cycle slot_de=0, cpu_stall=0, state IDLE, cpu_dout=0, bus_err=0. A fresh read then completes normally.
- Back-to-back reads of slots 0 then 1, CPU changing the address the cycle after stall drops: two separate BUSY phases with the correct slot_de each; no access is dropped or duplicated.
